// File: rtl/riscv_multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory side.
// The sequencer takes the master modport. The datapath takes the slave modport.
interface riscv_multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_source;
    logic             ir_write;
    logic             IorD;
    logic             Mem_Read;
    logic             Mem_Write;
    logic             Mem_to_Reg;
    logic             Reg_Write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       ALU_op;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  Opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, ir_write, IorD, Mem_Read,
               Mem_Write, Mem_to_Reg, Reg_Write, alu_src_a, alu_src_b, ALU_op,
               illegal, retired, state
    );

    modport slave (
        output Opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ir_write, IorD, Mem_Read,
               Mem_Write, Mem_to_Reg, Reg_Write, alu_src_a, alu_src_b, ALU_op,
               illegal, retired, state
    );
endinterface

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory handshake on mem_ready, sticky illegal-opcode trap and retired-instruction count.
module riscv_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    riscv_multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        LOAD_WB  = 4'd5,
        MEM_WR   = 4'd6,
        EXEC_R   = 4'd7,
        EXEC_I   = 4'd8,
        ALU_WB   = 4'd9,
        BRANCH   = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    state_t           cur;
    state_t           nxt;
    logic [6:0]       op_q;
    logic             ill_q;
    logic [CNT_W-1:0] ret_q;
    logic             retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= IDLE;
            op_q  <= '0;
            ill_q <= 1'b0;
            ret_q <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) op_q <= bus.Opcode;
            // Flag rises on entry so it is already visible in the first TRAP cycle.
            if (nxt == TRAP) ill_q <= 1'b1;
            if (retire) ret_q <= ret_q + CNT_W'(1);
        end
    end

    always_comb begin
        nxt               = cur;
        retire            = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.IorD          = 1'b0;
        bus.Mem_Read      = 1'b0;
        bus.Mem_Write     = 1'b0;
        bus.Mem_to_Reg    = 1'b0;
        bus.Reg_Write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.ALU_op        = 2'b00;
        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                bus.Mem_Read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) nxt = DECODE;
            end
            DECODE: begin
                bus.alu_src_b = 2'b10;
                case (bus.Opcode)
                    OP_L, OP_S: nxt = MEM_ADDR;
                    OP_R:       nxt = EXEC_R;
                    OP_I:       nxt = EXEC_I;
                    OP_B:       nxt = BRANCH;
                    default:    nxt = TRAP;
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                nxt = (op_q == OP_L) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.Mem_Read = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) nxt = LOAD_WB;
            end
            LOAD_WB: begin
                bus.Reg_Write  = 1'b1;
                bus.Mem_to_Reg = 1'b1;
                retire         = 1'b1;
                nxt            = FETCH;
            end
            MEM_WR: begin
                bus.Mem_Write = 1'b1;
                bus.IorD      = 1'b1;
                if (bus.mem_ready) begin
                    retire = 1'b1;
                    nxt    = FETCH;
                end
            end
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.ALU_op    = 2'b10;
                nxt           = ALU_WB;
            end
            EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.ALU_op    = 2'b11;
                nxt           = ALU_WB;
            end
            ALU_WB: begin
                bus.Reg_Write = 1'b1;
                retire        = 1'b1;
                nxt           = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.ALU_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 1'b1;
                retire            = 1'b1;
                nxt               = FETCH;
            end
            TRAP:    nxt = TRAP;
            default: nxt = IDLE;
        endcase
    end

    assign bus.illegal = ill_q;
    assign bus.retired = ret_q;
    assign bus.state   = cur;
endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Directed bench for riscv_multicycle_control: per-cycle expected state/control/retired/illegal
// values are queued as stimulus is driven and compared once the DUT outputs settle.
module tb_riscv_multicycle_control;
    localparam int CNT_W = 4;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
                           S_MEM_RD = 4'd4, S_LOAD_WB = 4'd5, S_MEM_WR = 4'd6, S_EXEC_R = 4'd7,
                           S_EXEC_I = 4'd8, S_ALU_WB = 4'd9, S_BRANCH = 4'd10, S_TRAP = 4'd11;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                           OP_S = 7'b0100011, OP_B = 7'b1100011, OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [3:0]       st;
        logic [13:0]      ctrl;
        logic [CNT_W-1:0] ret;
        logic             ill;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [6:0]       cur_op;
    logic [CNT_W-1:0] exp_ret;
    logic             exp_ill;
    exp_t             sb[$];
    int               errors;
    int               checks;

    riscv_multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    riscv_multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $error("FAIL watchdog sim_time got=%0t want<100000", $time);
        $fatal(1, "watchdog expired");
    end

    // Control vector order: pw, pwc, psrc, irw, IorD, MemRead, MemWrite, M2R, RegWrite, srcA, srcB[2], ALUop[2]
    function automatic logic [13:0] ctrl_for(input logic [3:0] s, input logic mr);
        logic [13:0] c;
        c = '0;
        case (s)
            S_FETCH:    c = {mr, 1'b0, 1'b0, mr, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
            S_DECODE:   c = {9'b0, 1'b0, 2'b10, 2'b00};
            S_MEM_ADDR: c = {9'b0, 1'b1, 2'b10, 2'b00};
            S_MEM_RD:   c = {4'b0, 1'b1, 1'b1, 3'b0, 1'b0, 2'b00, 2'b00};
            S_LOAD_WB:  c = {7'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
            S_MEM_WR:   c = {4'b0, 1'b1, 1'b0, 1'b1, 2'b0, 1'b0, 2'b00, 2'b00};
            S_EXEC_R:   c = {9'b0, 1'b1, 2'b00, 2'b10};
            S_EXEC_I:   c = {9'b0, 1'b1, 2'b10, 2'b11};
            S_ALU_WB:   c = {8'b0, 1'b1, 1'b0, 2'b00, 2'b00};
            S_BRANCH:   c = {1'b0, 1'b1, 1'b1, 6'b0, 1'b1, 2'b00, 2'b01};
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic logic rnd();
        int unsigned r;
        r = $urandom_range(0, 1);
        return r[0];
    endfunction

    task automatic push_exp(input logic [3:0] s, input logic mr);
        exp_t e;
        if (s == S_TRAP) exp_ill = 1'b1;
        e.st   = s;
        e.ctrl = ctrl_for(s, mr);
        e.ret  = exp_ret;
        e.ill  = exp_ill;
        sb.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t        e;
        logic [13:0] obs;
        e   = sb.pop_front();
        obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.ir_write, bus.IorD,
               bus.Mem_Read, bus.Mem_Write, bus.Mem_to_Reg, bus.Reg_Write, bus.alu_src_a,
               bus.alu_src_b, bus.ALU_op};
        checks++;
        assert (bus.state === e.st) else begin
            errors++;
            $error("FAIL %s state got=%0d want=%0d", tag, bus.state, e.st);
        end
        checks++;
        assert (obs === e.ctrl) else begin
            errors++;
            $error("FAIL %s ctrl(st=%0d) got=%b want=%b", tag, e.st, obs, e.ctrl);
        end
        checks++;
        assert (bus.retired === e.ret) else begin
            errors++;
            $error("FAIL %s retired got=%0d want=%0d", tag, bus.retired, e.ret);
        end
        checks++;
        assert (bus.illegal === e.ill) else begin
            errors++;
            $error("FAIL %s illegal got=%b want=%b", tag, bus.illegal, e.ill);
        end
    endtask

    // Called at a falling edge: drive, check the settled outputs, advance to the next falling edge.
    task automatic step(input string tag, input logic [3:0] s, input logic mr);
        bus.Opcode    = cur_op;
        bus.mem_ready = mr;
        push_exp(s, mr);
        #1;
        check_pop(tag);
        if (s == S_LOAD_WB || s == S_ALU_WB || s == S_BRANCH || (s == S_MEM_WR && mr))
            exp_ret = exp_ret + 1'b1;
        @(negedge clk);
    endtask

    task automatic instr(input string tag, input logic [6:0] op,
                         input int unsigned fw, input int unsigned mw);
        cur_op = op;
        for (int unsigned i = 0; i < fw; i++) step(tag, S_FETCH, 1'b0);
        step(tag, S_FETCH, 1'b1);
        step(tag, S_DECODE, rnd());
        // Later states must rely on the opcode captured in DECODE.
        cur_op = 7'h55;
        case (op)
            OP_R: begin step(tag, S_EXEC_R, rnd()); step(tag, S_ALU_WB, rnd()); end
            OP_I: begin step(tag, S_EXEC_I, rnd()); step(tag, S_ALU_WB, rnd()); end
            OP_L: begin
                step(tag, S_MEM_ADDR, rnd());
                for (int unsigned i = 0; i < mw; i++) step(tag, S_MEM_RD, 1'b0);
                step(tag, S_MEM_RD, 1'b1);
                step(tag, S_LOAD_WB, rnd());
            end
            OP_S: begin
                step(tag, S_MEM_ADDR, rnd());
                for (int unsigned i = 0; i < mw; i++) step(tag, S_MEM_WR, 1'b0);
                step(tag, S_MEM_WR, 1'b1);
            end
            OP_B: step(tag, S_BRANCH, rnd());
            default: step(tag, S_TRAP, rnd());
        endcase
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        exp_ret       = '0;
        exp_ill       = 1'b0;
        cur_op        = '0;
        rst_n         = 1'b0;
        bus.Opcode    = '0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        push_exp(S_IDLE, 1'b1);
        check_pop("reset");
        rst_n = 1'b1;
        step("idle", S_IDLE, 1'b1);

        instr("R",  OP_R, 0, 0);
        instr("LD", OP_L, 2, 3);
        instr("ST", OP_S, 0, 0);
        instr("BR", OP_B, 0, 0);
        instr("I",  OP_I, 0, 0);

        // Store stalled in MEM_WR, then reset asserted between clock edges.
        cur_op = OP_S;
        step("st_rst", S_FETCH, 1'b1);
        step("st_rst", S_DECODE, 1'b1);
        step("st_rst", S_MEM_ADDR, 1'b0);
        step("st_rst", S_MEM_WR, 1'b0);
        bus.mem_ready = 1'b0;
        #2;
        rst_n   = 1'b0;
        exp_ret = '0;
        exp_ill = 1'b0;
        push_exp(S_IDLE, 1'b0);
        #1;
        check_pop("async_rst");
        repeat (2) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            push_exp(S_IDLE, 1'b1);
            #1;
            check_pop("in_rst");
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("idle2", S_IDLE, 1'b0);

        for (int i = 0; i < 16; i++) instr("wrap", OP_R, 0, 0);
        checks++;
        assert (bus.retired === 4'd0) else begin
            errors++;
            $error("FAIL wrap_final retired got=%0d want=0", bus.retired);
        end

        instr("R2", OP_R, 0, 0);
        instr("ILL", OP_BAD, 0, 0);
        repeat (20) step("trap", S_TRAP, rnd());

        rst_n   = 1'b0;
        exp_ret = '0;
        exp_ill = 1'b0;
        push_exp(S_IDLE, 1'b0);
        #1;
        check_pop("trap_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle3", S_IDLE, 1'b1);
        cur_op = OP_B;
        step("post", S_FETCH, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_multicycle_control.md
Name: riscv_multicycle_control

Overview:
- Multi-cycle sequencer for the RISC-V datapath. It replaces the single-cycle opcode decoder with an FSM.
- Each instruction is split into fetch, decode, execute, memory and writeback steps, sharing one ALU and one unified memory port.
- Sits between the instruction register (opcode source) and the datapath muxes and enables. It handshakes with memory through mem_ready and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
- mem_ready  input  1  memory has completed the current access this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load gated by ALU zero (branch).
- pc_source  output  1  0 = ALU result, 1 = ALUOut register.
- ir_write  output  1  instruction register load.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- Mem_Read  output  1  memory read request.
- Mem_Write  output  1  memory write request.
- Mem_to_Reg  output  1  writeback select: 1 = memory data register, 0 = ALUOut.
- Reg_Write  output  1  register file write enable.
- alu_src_a  output  1  0 = PC, 1 = rs1.
- alu_src_b  output  2  00 = rs2, 01 = constant 4, 10 = immediate.
- ALU_op  output  2  00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct.
- illegal  output  1  sticky unsupported-opcode flag.
- retired  output  CNT_W  count of completed instructions.
- state  output  4  current state encoding, for debug.

Behaviour:
- Supported opcodes:
  - R 0110011
  - I 0010011
  - L 0000011
  - S 0100011
  - B 1100011
  - Anything else goes to TRAP.
- Reset (rst_n low, asynchronous):
  - state = IDLE, retired = 0, illegal = 0, internal opcode latch = 0.
  - All control outputs 0.
- Control outputs are decoded combinationally from state. The exception is FETCH, where ir_write and pc_write also depend on mem_ready. Any output not listed for a state is 0.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - Mem_Read = 1, IorD = 0, alu_src_a = 0, alu_src_b = 01, ALU_op = 00, pc_source = 0.
  - Stays in FETCH while mem_ready = 0.
  - When mem_ready = 1: ir_write = 1 and pc_write = 1 in that same cycle, then go to DECODE.
- DECODE:
  - alu_src_a = 0, alu_src_b = 10, ALU_op = 00 (computes the branch target into ALUOut).
  - Latch Opcode internally; all later states use the latched value.
  - Next state: L or S → MEM_ADDR; R → EXEC_R; I → EXEC_I; B → BRANCH; otherwise TRAP.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, ALU_op = 00. Next: latched L → MEM_RD, latched S → MEM_WR.
- MEM_RD: Mem_Read = 1, IorD = 1. Holds until mem_ready, then LOAD_WB.
- LOAD_WB: Reg_Write = 1, Mem_to_Reg = 1; next FETCH.
- MEM_WR: Mem_Write = 1, IorD = 1. Holds until mem_ready, then FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, ALU_op = 10; next ALU_WB.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, ALU_op = 11; next ALU_WB.
- ALU_WB: Reg_Write = 1, Mem_to_Reg = 0; next FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, ALU_op = 01, pc_write_cond = 1, pc_source = 1; next FETCH.
- TRAP: illegal set to 1 and held. All other outputs 0. No exit except reset.
- Retired counter:
  - Increments by 1 on the clock edge leaving LOAD_WB, ALU_WB or BRANCH, or leaving MEM_WR with mem_ready = 1.
  - Wraps from all-ones to 0.
  - Never increments in TRAP.
- Cycle counts with zero-wait memory, measured from entering FETCH:
  - R / I: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle (mem_ready = 0) in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_ready is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored in all other states.
- Mem_Read and Mem_Write are never both 1.
- Reset mid-instruction: the FSM returns to IDLE immediately. No partial Reg_Write or Mem_Write is asserted after rst_n falls.
- Unused state encodings go to IDLE on the next clock.

Test Plan:
- Reset, then release; R-type opcode, mem_ready held 1 → state sequence IDLE, FETCH, DECODE, EXEC_R, ALU_WB, FETCH. ALU_op = 10 in EXEC_R, Reg_Write = 1 only in ALU_WB, retired = 1.
- Load with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles from FETCH entry to next FETCH. ir_write pulses exactly once; Reg_Write and Mem_to_Reg = 1 only in LOAD_WB.
- Store, then branch, then I-type, zero-wait → 4 + 3 + 4 cycles. Mem_Write is high for exactly 1 cycle with IorD = 1; pc_write_cond = 1 only in BRANCH; retired = 3.
- Opcode 1111111 → TRAP after DECODE. illegal = 1 and stays 1 for 20 cycles; all enables 0; retired unchanged; rst_n pulse clears illegal.
- rst_n asserted low during MEM_WR while mem_ready = 0 → outputs go to 0 asynchronously, state = IDLE, no Mem_Write afterwards, retired = 0.
- Preload near wrap (CNT_W = 4), run 16 R-type instructions → retired goes 15 → 0 with no glitch.
